// File: rtl/fpu_sign_pipe.sv
// fpu_sign_pipe: per-lane result-sign resolution for floating-point add/sub,
// carried through a PIPE_STAGES-deep valid/ready pipeline that collapses bubbles.
// Optional feature macro: FPU_SIGN_STAT_EN adds o_invalid_cnt, a saturating
// count of invalid lanes seen on output handshakes.
module fpu_sign_pipe #(
    parameter int NUM_LANE    = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NUM_LANE-1:0] i_add_sub,
    input  logic [NUM_LANE-1:0] i_sign_man_a,
    input  logic [NUM_LANE-1:0] i_sign_man_b,
    input  logic [NUM_LANE-1:0] i_comp_man,
    input  logic [NUM_LANE-1:0] i_eq_man,
    input  logic [NUM_LANE-1:0] i_inf_a,
    input  logic [NUM_LANE-1:0] i_inf_b,
    input  logic [NUM_LANE-1:0] i_nan,
    input  logic                i_rnd_down,
    output logic                o_valid,
    input  logic                i_ready,
`ifdef FPU_SIGN_STAT_EN
    output logic [15:0]         o_invalid_cnt,
`endif
    output logic [NUM_LANE-1:0] o_sign_s,
    output logic [NUM_LANE-1:0] o_invalid
);

    localparam int LAST = PIPE_STAGES - 1;

    // Returns {invalid, sign} for one lane, highest-priority case first.
    function automatic logic [1:0] f_lane_sign(
        input logic sub, input logic sa, input logic sb, input logic comp,
        input logic eq, input logic inf_a, input logic inf_b, input logic nan,
        input logic rnd
    );
        logic       eb;
        logic [1:0] res;
        eb = sb ^ sub;                     // effective sign of the B term
        if (nan)                  res = 2'b00;
        else if (inf_a && inf_b)  res = (sa == eb) ? {1'b0, sa} : 2'b10;
        else if (inf_a)           res = {1'b0, sa};
        else if (inf_b)           res = {1'b0, eb};
        else if (eq && (sa != eb)) res = {1'b0, rnd};   // exact cancellation
        else                      res = {1'b0, comp ? eb : sa};
        return res;
    endfunction

    logic [NUM_LANE-1:0] w_in_sign;
    logic [NUM_LANE-1:0] w_in_inv;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANE; gi++) begin : g_lane
            assign {w_in_inv[gi], w_in_sign[gi]} = f_lane_sign(
                i_add_sub[gi], i_sign_man_a[gi], i_sign_man_b[gi], i_comp_man[gi],
                i_eq_man[gi], i_inf_a[gi], i_inf_b[gi], i_nan[gi], i_rnd_down);
        end
    endgenerate

    logic [PIPE_STAGES-1:0] w_stage_vld;
    logic [PIPE_STAGES-1:0] w_load;
    logic [PIPE_STAGES-1:0] w_adv;
    logic [NUM_LANE-1:0]    w_stage_sign [PIPE_STAGES];
    logic [NUM_LANE-1:0]    w_stage_inv  [PIPE_STAGES];

    // Back-to-front: a stage advances if it holds a beat and its downstream
    // loads; it loads if empty or advancing. This collapses bubbles.
    always_comb begin
        logic w_go;
        w_adv  = '0;
        w_load = '0;
        w_go   = i_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_adv[k]  = w_stage_vld[k] & w_go;
            w_load[k] = ~w_stage_vld[k] | w_adv[k];
            w_go      = w_load[k];
        end
    end

    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic                r_vld;
            logic [NUM_LANE-1:0] r_sign;
            logic [NUM_LANE-1:0] r_inv;

            if (gi == 0) begin : g_first
                // Stage 0 captures the resolved lane results on input handshake.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_vld  <= 1'b0;
                        r_sign <= '0;
                        r_inv  <= '0;
                    end else begin
                        if (w_load[0])
                            r_vld <= i_valid;
                        if (w_load[0] && i_valid) begin
                            r_sign <= w_in_sign;
                            r_inv  <= w_in_inv;
                        end
                    end
                end
            end else begin : g_next
                // Later stages take the upstream beat whenever they load.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_vld  <= 1'b0;
                        r_sign <= '0;
                        r_inv  <= '0;
                    end else begin
                        if (w_load[gi])
                            r_vld <= w_stage_vld[gi-1];
                        if (w_load[gi] && w_stage_vld[gi-1]) begin
                            r_sign <= w_stage_sign[gi-1];
                            r_inv  <= w_stage_inv[gi-1];
                        end
                    end
                end
            end

            assign w_stage_vld[gi]  = r_vld;
            assign w_stage_sign[gi] = r_sign;
            assign w_stage_inv[gi]  = r_inv;
        end
    endgenerate

    assign o_ready   = w_load[0];
    assign o_valid   = w_stage_vld[LAST];
    assign o_sign_s  = w_stage_sign[LAST];
    assign o_invalid = w_stage_inv[LAST];

`ifdef FPU_SIGN_STAT_EN
    logic [15:0] r_invalid_cnt;
    logic [4:0]  w_pop;
    logic [16:0] w_cnt_sum;

    // Popcount of invalid lanes on the outgoing beat, widened for overflow.
    always_comb begin
        w_pop     = 5'($countones(o_invalid));
        w_cnt_sum = {1'b0, r_invalid_cnt} + {12'b0, w_pop};
    end

    // Saturating accumulation on every output handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_invalid_cnt <= '0;
        else if (o_valid && i_ready)
            r_invalid_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    assign o_invalid_cnt = r_invalid_cnt;
`endif

endmodule

// File: tb/tb_fpu_sign_pipe.sv
// Self-checking bench for fpu_sign_pipe (NUM_LANE = 4, PIPE_STAGES = 2).
module tb_fpu_sign_pipe;

    localparam int NL = 4;

    typedef struct {
        logic [NL-1:0] sub, a, b, comp, eq, infa, infb, nan;
        logic          rnd;
        logic [NL-1:0] es, ei;
    } vec_t;

    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b1;
    logic i_rnd_down = 1'b0;
    logic [NL-1:0] i_add_sub = '0, i_sign_man_a = '0, i_sign_man_b = '0;
    logic [NL-1:0] i_comp_man = '0, i_eq_man = '0, i_inf_a = '0, i_inf_b = '0, i_nan = '0;
    logic o_ready, o_valid;
    logic [NL-1:0] o_sign_s, o_invalid;
`ifdef FPU_SIGN_STAT_EN
    logic [15:0] o_invalid_cnt;
`endif

    fpu_sign_pipe #(.NUM_LANE(NL), .PIPE_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_add_sub(i_add_sub), .i_sign_man_a(i_sign_man_a), .i_sign_man_b(i_sign_man_b),
        .i_comp_man(i_comp_man), .i_eq_man(i_eq_man), .i_inf_a(i_inf_a), .i_inf_b(i_inf_b),
        .i_nan(i_nan), .i_rnd_down(i_rnd_down), .o_valid(o_valid), .i_ready(i_ready),
`ifdef FPU_SIGN_STAT_EN
        .o_invalid_cnt(o_invalid_cnt),
`endif
        .o_sign_s(o_sign_s), .o_invalid(o_invalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl [10];
    logic [2*NL-1:0] sb [$];
    logic [NL-1:0] cur_es = '0, cur_ei = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [NL-1:0] sub, a, b, comp, eq, infa, infb, nan,
                                input logic rnd, input logic [NL-1:0] es, ei);
        vec_t v;
        v.sub = sub; v.a = a; v.b = b; v.comp = comp; v.eq = eq;
        v.infa = infa; v.infb = infb; v.nan = nan; v.rnd = rnd; v.es = es; v.ei = ei;
        return v;
    endfunction

    task automatic set_beat(input int i);
        i_add_sub = tbl[i].sub;  i_sign_man_a = tbl[i].a; i_sign_man_b = tbl[i].b;
        i_comp_man = tbl[i].comp; i_eq_man = tbl[i].eq;
        i_inf_a = tbl[i].infa;   i_inf_b = tbl[i].infb;  i_nan = tbl[i].nan;
        i_rnd_down = tbl[i].rnd;
        cur_es = tbl[i].es; cur_ei = tbl[i].ei;
        i_valid = 1'b1;
    endtask

    // Waits (bounded) for the presented beat to be accepted; returns #1 after that edge.
    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        check({"accept_", tag}, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0 && !o_valid) break;
            @(negedge clk);
        end
        check({"drain_", tag}, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: compare outgoing beats, then record newly accepted ones.
    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    logic [2*NL-1:0] e;
                    e = sb.pop_front();
                    check("beat_sign", 32'(o_sign_s), 32'(e[2*NL-1:NL]));
                    check("beat_invalid", 32'(o_invalid), 32'(e[NL-1:0]));
                end
            end
            if (i_valid && o_ready) sb.push_back({cur_es, cur_ei});
        end
    end

    initial begin
        //            sub      a        b        comp     eq       infa     infb     nan    rnd  es       ei
        tbl[0] = mk(4'b1001, 4'b0110, 4'b0001, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1100, 4'b0000);
        tbl[1] = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
        tbl[2] = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 4'b1111, 4'b0000);
        tbl[3] = mk(4'b1001, 4'b0110, 4'b1000, 4'b0000, 4'b0000, 4'b0011, 4'b1001, 4'b0100, 0, 4'b0010, 4'b0001);
        tbl[4] = mk(4'b0000, 4'b0011, 4'b1011, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0011, 4'b1000);
        tbl[5] = mk(4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0011, 1, 4'b1100, 4'b0000);
        tbl[6] = mk(4'b0000, 4'b0011, 4'b0011, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0011, 4'b0000);
        tbl[7] = mk(4'b1111, 4'b0000, 4'b0101, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b0000);
        tbl[8] = mk(4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0011);
        tbl[9] = mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 4'b1111);

        // Reset values
        #12;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_sign_s", 32'(o_sign_s), 32'd0);
        check("rst_o_invalid", 32'(o_invalid), 32'd0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: accepted at edge N, visible after edge N+1
        set_beat(0);
        wait_accept("lat");
        i_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(o_valid), 32'd1);
        drain("lat");

        // Table vectors streamed back-to-back
        for (int i = 0; i < 8; i++) begin
            set_beat(i);
            wait_accept($sformatf("tbl%0d", i));
            $display("vector %0d accepted", i);
        end
        i_valid = 1'b0;
        drain("tbl");

        // Back-pressure: six beats with downstream stalled
        i_ready = 1'b0;
        set_beat(0); wait_accept("bp0");
        set_beat(1); wait_accept("bp1");
        set_beat(2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_full_ready", 32'(o_ready), 32'd0);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_sign", 32'(o_sign_s), 32'(tbl[0].es));
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 3; i < 6; i++) begin
            set_beat(i);
            wait_accept($sformatf("bp%0d", i));
        end
        i_valid = 1'b0;
        drain("bp");

        // Bubble: beats in cycles 0 and 3 -> o_valid only in cycles 2 and 5
        for (int c = 0; c < 8; c++) begin
            set_beat(c == 0 ? 6 : 7);
            i_valid = (c == 0 || c == 3);
            @(negedge clk);
            check($sformatf("bubble_c%0d", c), 32'(o_valid), 32'((c == 2 || c == 5) ? 1 : 0));
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        drain("bubble");

        // Reset with two beats in flight
        i_ready = 1'b0;
        set_beat(3); wait_accept("rf0");
        set_beat(4); wait_accept("rf1");
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        check("midrst_o_invalid", 32'(o_invalid), 32'd0);
        check("midrst_o_ready", 32'(o_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        check("midrst_no_ghost", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        set_beat(7); wait_accept("recover");
        i_valid = 1'b0;
        drain("recover");

`ifdef FPU_SIGN_STAT_EN
        check("cnt_after_rst", 32'(o_invalid_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_beat(8); wait_accept("cnt");
        end
        i_valid = 1'b0;
        drain("cnt");
        check("cnt_six", 32'(o_invalid_cnt), 32'd6);
        set_beat(9);
        for (int j = 0; j < 16383; j++) wait_accept("sat");
        i_valid = 1'b0;
        drain("sat");
        check("cnt_saturated", 32'(o_invalid_cnt), 32'hFFFF);
        set_beat(9); wait_accept("sat_more");
        i_valid = 1'b0;
        drain("sat_more");
        check("cnt_stays_sat", 32'(o_invalid_cnt), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_sign_pipe.md
# fpu_sign_pipe

Parametrised, pipelined successor to the single-lane sign unit of the floating-point add/sub datapath. It resolves the result sign for NUM_LANE parallel add/sub operations, including infinity, NaN and exact-cancellation cases. Results travel through a PIPE_STAGES-deep valid/ready pipeline with bubble collapsing. It sits between the exponent/mantissa compare stage and the normaliser/packer.

## Interface
- NUM_LANE, 4: parallel lanes; legal range 1..16.
- PIPE_STAGES, 2: register stages; legal range 1..4.
- i_clk  in  1  clock; rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  pipeline can accept a beat this cycle.
- i_add_sub  in  NUM_LANE  per lane; 1 = subtract (A-B), 0 = add.
- i_sign_man_a  in  NUM_LANE  sign of A.
- i_sign_man_b  in  NUM_LANE  sign of B.
- i_comp_man  in  NUM_LANE  1 = |B| > |A|.
- i_eq_man  in  NUM_LANE  1 = |A| == |B|.
- i_inf_a, i_inf_b  in  NUM_LANE each  operand is infinity.
- i_nan  in  NUM_LANE  either operand is NaN.
- i_rnd_down  in  1  rounding toward -inf; shared by all lanes.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_sign_s  out  NUM_LANE  result sign.
- o_invalid  out  NUM_LANE  invalid operation (inf - inf).
- o_invalid_cnt  out  16  saturating count of invalid lanes; present only with the macro.

## Operation
- Per lane, evaluated on input capture: eb = i_sign_man_b ^ i_add_sub. Priority order, highest first:
  1. i_nan: sign 0, invalid 0.
  2. i_inf_a & i_inf_b: if sign_a == eb, sign = sign_a and invalid 0; otherwise sign 0 and invalid 1.
  3. i_inf_a only: sign = sign_a. i_inf_b only: sign = eb.
  4. i_eq_man & (sign_a != eb), i.e. exact cancellation: sign = i_rnd_down.
  5. Otherwise: sign = i_comp_man ? eb : sign_a.
- Pipeline: PIPE_STAGES registers, each holding a valid bit and the lane payload.
  - Stage k loads when it is empty or stage k+1 (or the output for the last stage) advances this cycle. Bubbles therefore collapse.
  - o_ready = stage 0 empty, or stage 0 advancing. It is combinational and never depends on i_valid.
  - Input captured when i_valid & o_ready. The output beat is consumed when o_valid & i_ready.
  - o_valid and the payload of the last stage hold stable while i_ready = 0.
  - Payload registers load only on capture or advance; payload of empty stages is don't-care internally.
- Reset mid-operation: every stage's valid clears immediately, in-flight beats are discarded, and the counter clears.

## Timing
- Reset values: o_valid 0, o_sign_s 0, o_invalid 0, o_invalid_cnt 0. After reset o_ready = 1.
- Latency: beat accepted at edge N appears with o_valid = 1 after edge N+PIPE_STAGES-1, i.e. visible in cycle N+PIPE_STAGES-1 with PIPE_STAGES = 1 meaning the next cycle.
- Throughput: one beat per cycle when i_ready is held at 1.
- Capacity: PIPE_STAGES beats. Once full with i_ready = 0, o_ready = 0.
- Full pipeline with i_ready rising: in that same cycle, o_ready = 1, and accept and drain happen simultaneously.

## Configuration
- Macro FPU_SIGN_STAT_EN.
- Defined: o_invalid_cnt exists. It adds popcount(o_invalid) on each output handshake and saturates at 16'hFFFF.
- Undefined: port and counter are absent. Sign and handshake behaviour is identical either way.

## Test plan
- NUM_LANE = 4, PIPE_STAGES = 2. Lane 0: a = 0, b = 1, sub = 1, comp = 0 -> eb = 0, sign 0. Lane 1: a = 1, comp = 1, b = 0, add -> sign 0. Lane 2: a = 1, comp = 0 -> sign 1. Lane 3: sub, b = 0, comp = 1 -> sign 1. Expect o_sign_s = 4'b1100, o_valid after 2 edges.
- Cancellation: a = 0, b = 0, sub = 1, eq = 1 on all lanes. i_rnd_down = 0 -> 4'b0000; i_rnd_down = 1 -> 4'b1111.
- Specials: lane 0 inf_a & inf_b, a = 0, b = 0, sub -> invalid 1, sign 0. Lane 1 inf_a, a = 1 -> sign 1. Lane 2 nan with a = 1 -> sign 0. Lane 3 inf_b, b = 1, sub -> sign 0. Expect o_invalid = 4'b0001.
- Back-pressure: stream 6 beats with i_ready = 0. o_ready drops after 2 accepts. Raise i_ready: all 6 beats emerge in order with no loss and no duplicates. o_sign_s is held stable while stalled.
- Bubble: beats in cycles 0 and 3, i_ready = 1 throughout -> o_valid pulses in cycles 2 and 5 only.
- Reset with 2 beats in flight -> o_valid = 0 immediately. With FPU_SIGN_STAT_EN: 3 beats each with 2 invalid lanes give cnt = 6. Force 0xFFFF followed by another invalid beat -> cnt stays 0xFFFF.
